mul_acc_int32: RTL
==================

Name: mul_acc_int32

Overview:
- Downstream consumer of the 32-bit integer multiplier stage.
- Accepts a stream of lower-32-bit products P over a valid/ready handshake and accumulates them modulo 2^WIDTH over a programmed vector length.
- Presents the dot-product result on a valid/ready output handshake.
- Forms the sequential back end of the dot-product benchmark pipeline (multiplier feeds P, this block reduces).

Parameters:
- WIDTH, 32, data width of products and accumulator (result is lower WIDTH bits).
- LEN_WIDTH, 16, width of vector-length field and beat counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a reduction; sampled only in IDLE.
- len  input  LEN_WIDTH  number of products to accumulate; sampled with start.
- abort  input  1  synchronous cancel of a reduction in progress.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block accepts a product this cycle.
- P  input  WIDTH  product from the multiplier stage.
- out_valid  output  1  SUM is valid.
- out_ready  input  1  consumer accepts SUM.
- SUM  output  WIDTH  accumulated result, modulo 2^WIDTH.
- ovf  output  1  sticky flag: at least one unsigned carry out of the accumulator during this reduction.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - acc=0, cnt=0, len_q=0, ovf=0, out_valid=0, SUM=0.
  - in_ready=0, busy=0.
- States:
  - IDLE: in_ready=0, out_valid=0.
    - start=1 and len!=0: latch len_q=len, clear acc, cnt and ovf, go to ACC.
    - start=1 and len==0: clear acc and ovf, go to DONE directly (SUM=0).
  - ACC: in_ready = !abort.
    - A beat is accepted when in_valid && in_ready.
    - On acceptance: acc <= acc+P, truncated to WIDTH bits; ovf |= carry out; cnt <= cnt+1.
    - On acceptance with cnt==len_q-1: go to DONE. The last beat's contribution is included in SUM.
    - abort=1: go to IDLE, no beat accepted that cycle, out_valid never asserts, acc is not published.
  - DONE: out_valid=1, SUM=acc, ovf held.
    - out_ready=1: go to IDLE next cycle.
    - out_valid stays high and SUM/ovf stay stable until accepted.
    - abort in DONE is ignored.
- Latency:
  - First beat may be accepted the cycle after start.
  - out_valid rises the cycle after the last accepted beat.
  - Throughput is one beat per cycle with continuous in_valid. Minimum reduction time is len+1 cycles from start to out_valid.
- start while busy is ignored. len is not re-sampled.
- SUM and ovf outputs hold their last values in IDLE until the next start clears them. out_valid=0 in IDLE.
- in_valid in IDLE or DONE is ignored (in_ready=0). The upstream stage must hold the beat.
- Arithmetic:
  - Unsigned addition modulo 2^WIDTH.
  - Result equals the lower WIDTH bits of the signed sum as well (two's complement), so no sign handling is needed.
- Counter wrap: cnt never exceeds len_q-1. len = 2^LEN_WIDTH-1 is legal.
- Reset asserted mid-reduction: immediate return to reset values. Partial sum is discarded. No spurious out_valid after release.
- Reset deassertion is synchronized externally. The block requires no synchronizer.

Test Plan:
- start, len=4; P=3,5,7,9 with in_valid held -> out_valid 5 cycles after start, SUM=24, ovf=0; out_ready=1 -> IDLE, busy=0.
- len=2; P=0xFFFFFFFF, 0x00000002 -> SUM=0x00000001, ovf=1. Second run: len=1, P=5 -> SUM=5, ovf=0 (sticky cleared by start).
- len=3 with in_valid toggling 1,0,1,0,1 and out_ready held 0 for 4 cycles -> only 3 beats counted. SUM stable and out_valid high throughout the stall. in_ready=0 while in DONE.
- len=0 start -> out_valid next cycle, SUM=0. A start pulse during DONE is ignored, and SUM is unchanged after the handshake.
- len=5, abort after 2 beats concurrent with in_valid=1 -> in_ready=0 that cycle, IDLE next cycle, out_valid never asserts. A new start with len=1, P=7 gives SUM=7.
- len=4, rst_n pulled low after 2 beats -> outputs zero immediately. After release, out_valid stays 0 until a new start completes.

Source files
------------

// File: rtl/mul_acc_int32.sv
// Dot-product back end: accumulates a programmed number of WIDTH-bit products
// modulo 2^WIDTH and presents the sum over a valid/ready handshake.
module mul_acc_int32 #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     P,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     SUM,
    output logic                 ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [WIDTH:0]       add;

    // State and datapath registers; out_valid/busy are registered decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Next-state, datapath update and handshake decode
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        add      = {1'b0, acc_q} + {1'b0, P};

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        len_d   = len;
                        state_d = ACC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACC: begin
                in_ready = !abort;
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    acc_d = add[WIDTH-1:0];
                    ovf_d = ovf_q | add[WIDTH];
                    // Counter returns to zero on the last beat so it never passes len_q-1
                    if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign SUM       = acc_q;
    assign ovf       = ovf_q;

endmodule
